// File: rtl/connect4_turn_ctrl.sv
// Connect Four turn sequencer: scans the requested column bottom-up, places the
// current player's chip, strobes the win checker, then resolves win/draw/next turn.
module connect4_turn_ctrl #(
    parameter int   ROWS         = 6,
    parameter int   COLS         = 7,
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [2:0]           col_sel,
    input  logic                 drop,
    input  logic                 new_game,
    input  logic                 red_win_in,
    input  logic                 yellow_win_in,
    output logic [ROWS*COLS-1:0] red,
    output logic [ROWS*COLS-1:0] yellow,
    output logic                 check_red,
    output logic                 check_yellow,
    output logic                 clr_n,
    output logic                 turn,
    output logic                 drop_ack,
    output logic                 drop_rej,
    output logic [5:0]           last_pos,
    output logic [5:0]           move_count,
    output logic                 game_over,
    output logic [1:0]           winner,
    output logic                 draw
);

    localparam int               N        = ROWS * COLS;
    localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [5:0]       CELLS    = 6'(N);
    localparam logic [5:0]       COLS_W6  = 6'(COLS);
    localparam logic [2:0]       COLS_W3  = 3'(COLS);
    localparam logic [ROW_W-1:0] ROW_BOT  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_TOP  = ROW_W'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIND  = 3'd1,
        S_CHECK = 3'd2,
        S_EVAL  = 3'd3,
        S_OVER  = 3'd4
    } state_e;

    function automatic logic [5:0] cell_index(input logic [ROW_W-1:0] row,
                                              input logic [2:0]       col);
        return 6'(row) * COLS_W6 + 6'(col);
    endfunction

    state_e            state_q, state_d;
    logic [N-1:0]      red_q, red_d;
    logic [N-1:0]      yellow_q, yellow_d;
    logic              turn_q, turn_d;
    logic [2:0]        col_q, col_d;
    logic [ROW_W-1:0]  scan_row_q, scan_row_d;
    logic [5:0]        last_pos_q, last_pos_d;
    logic [5:0]        move_count_q, move_count_d;
    logic [1:0]        winner_q, winner_d;
    logic              draw_q, draw_d;
    logic              game_over_q, game_over_d;
    logic              check_red_q, check_red_d;
    logic              check_yellow_q, check_yellow_d;
    logic              drop_ack_q, drop_ack_d;
    logic              drop_rej_q, drop_rej_d;

    logic [5:0]        scan_idx_s;
    logic              cell_occ_s;
    logic              col_ok_s;
    logic              win_flag_s;

    assign scan_idx_s = cell_index(scan_row_q, col_q);
    assign cell_occ_s = red_q[scan_idx_s] | yellow_q[scan_idx_s];
    assign col_ok_s   = (col_sel < COLS_W3);
    assign win_flag_s = turn_q ? yellow_win_in : red_win_in;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; new_game overrides any move in flight
    always_comb begin
        state_d = state_q;
        if (new_game) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (drop && col_ok_s) begin
                        state_d = S_FIND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FIND: begin
                    if (!cell_occ_s) begin
                        state_d = S_CHECK;
                    end else if (scan_row_q == ROW_TOP) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FIND;
                    end
                end
                S_CHECK: state_d = S_EVAL;
                S_EVAL: begin
                    if (win_flag_s || (move_count_q == CELLS)) begin
                        state_d = S_OVER;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Board, bookkeeping and output-pulse next values
    always_comb begin
        red_d          = red_q;
        yellow_d       = yellow_q;
        turn_d         = turn_q;
        col_d          = col_q;
        scan_row_d     = scan_row_q;
        last_pos_d     = last_pos_q;
        move_count_d   = move_count_q;
        winner_d       = winner_q;
        draw_d         = draw_q;
        check_red_d    = 1'b0;
        check_yellow_d = 1'b0;
        drop_ack_d     = 1'b0;
        drop_rej_d     = 1'b0;
        if (new_game) begin
            red_d        = '0;
            yellow_d     = '0;
            turn_d       = FIRST_PLAYER;
            col_d        = 3'd0;
            scan_row_d   = ROW_TOP;
            last_pos_d   = 6'd0;
            move_count_d = 6'd0;
            winner_d     = 2'b00;
            draw_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (drop && col_ok_s) begin
                        col_d      = col_sel;
                        scan_row_d = ROW_BOT;
                    end else if (drop) begin
                        drop_rej_d = 1'b1;
                    end else begin
                        col_d = col_q;
                    end
                end
                S_FIND: begin
                    // The check strobe and ack are launched here so they are
                    // registered and coincide exactly with the CHECK state.
                    if (!cell_occ_s) begin
                        if (turn_q) begin
                            yellow_d[scan_idx_s] = 1'b1;
                        end else begin
                            red_d[scan_idx_s] = 1'b1;
                        end
                        last_pos_d     = scan_idx_s;
                        move_count_d   = move_count_q + 6'd1;
                        check_red_d    = ~turn_q;
                        check_yellow_d = turn_q;
                        drop_ack_d     = 1'b1;
                    end else if (scan_row_q == ROW_TOP) begin
                        drop_rej_d = 1'b1;
                    end else begin
                        scan_row_d = scan_row_q - ROW_W'(1);
                    end
                end
                S_EVAL: begin
                    if (win_flag_s) begin
                        winner_d = turn_q ? 2'b10 : 2'b01;
                    end else if (move_count_q == CELLS) begin
                        draw_d = 1'b1;
                    end else begin
                        turn_d = ~turn_q;
                    end
                end
                default: begin
                    turn_d = turn_q;
                end
            endcase
        end
        game_over_d = (state_d == S_OVER);
    end

    // Board and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            red_q          <= '0;
            yellow_q       <= '0;
            turn_q         <= FIRST_PLAYER;
            col_q          <= 3'd0;
            scan_row_q     <= ROW_TOP;
            last_pos_q     <= 6'd0;
            move_count_q   <= 6'd0;
            winner_q       <= 2'b00;
            draw_q         <= 1'b0;
            game_over_q    <= 1'b0;
            check_red_q    <= 1'b0;
            check_yellow_q <= 1'b0;
            drop_ack_q     <= 1'b0;
            drop_rej_q     <= 1'b0;
        end else begin
            red_q          <= red_d;
            yellow_q       <= yellow_d;
            turn_q         <= turn_d;
            col_q          <= col_d;
            scan_row_q     <= scan_row_d;
            last_pos_q     <= last_pos_d;
            move_count_q   <= move_count_d;
            winner_q       <= winner_d;
            draw_q         <= draw_d;
            game_over_q    <= game_over_d;
            check_red_q    <= check_red_d;
            check_yellow_q <= check_yellow_d;
            drop_ack_q     <= drop_ack_d;
            drop_rej_q     <= drop_rej_d;
        end
    end

    // The checker clear must be low in the very cycle new_game is sampled.
    assign clr_n        = ~new_game;
    assign red          = red_q;
    assign yellow       = yellow_q;
    assign turn         = turn_q;
    assign last_pos     = last_pos_q;
    assign move_count   = move_count_q;
    assign winner       = winner_q;
    assign draw         = draw_q;
    assign game_over    = game_over_q;
    assign check_red    = check_red_q;
    assign check_yellow = check_yellow_q;
    assign drop_ack     = drop_ack_q;
    assign drop_rej     = drop_rej_q;

endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// Scoreboard bench for connect4_turn_ctrl: a board model predicts each move's
// outcome and latency, and a small win-checker model answers the check strobes.
module tb_connect4_turn_ctrl;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int N    = ROWS * COLS;

    logic         clk = 1'b0;
    logic         resetn;
    logic [2:0]   col_sel;
    logic         drop;
    logic         new_game;
    logic         red_win_in;
    logic         yellow_win_in;
    logic [N-1:0] red;
    logic [N-1:0] yellow;
    logic         check_red;
    logic         check_yellow;
    logic         clr_n;
    logic         turn;
    logic         drop_ack;
    logic         drop_rej;
    logic [5:0]   last_pos;
    logic [5:0]   move_count;
    logic         game_over;
    logic [1:0]   winner;
    logic         draw;

    connect4_turn_ctrl #(.ROWS(ROWS), .COLS(COLS), .FIRST_PLAYER(1'b0)) dut (
        .clk(clk), .resetn(resetn), .col_sel(col_sel), .drop(drop),
        .new_game(new_game), .red_win_in(red_win_in), .yellow_win_in(yellow_win_in),
        .red(red), .yellow(yellow), .check_red(check_red), .check_yellow(check_yellow),
        .clr_n(clr_n), .turn(turn), .drop_ack(drop_ack), .drop_rej(drop_rej),
        .last_pos(last_pos), .move_count(move_count), .game_over(game_over),
        .winner(winner), .draw(draw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_ack;
        logic [5:0] pos;
        int         lat;
        logic       chk_r;
        logic       chk_y;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [N-1:0] red_m, yellow_m;
    logic         turn_m, over_m, draw_m;
    logic [1:0]   winner_m;
    int           count_m;
    logic         win_arm = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Win-checker model: registers its flag on the check strobe edge
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            red_win_in    <= 1'b0;
            yellow_win_in <= 1'b0;
        end else if (new_game) begin
            red_win_in    <= 1'b0;
            yellow_win_in <= 1'b0;
        end else begin
            if (check_red)    red_win_in    <= win_arm;
            if (check_yellow) yellow_win_in <= win_arm;
        end
    end

    always @(negedge clk) begin
        if (resetn && (check_red || check_yellow || drop_ack)) begin
            chk("chk_excl", 64'(check_red & check_yellow), 64'd0);
            chk("ack_vs_chk", 64'(drop_ack), 64'(check_red | check_yellow));
        end
    end

    task automatic model_reset();
        red_m = '0; yellow_m = '0; turn_m = 1'b0; over_m = 1'b0;
        draw_m = 1'b0; winner_m = 2'b00; count_m = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_red"},    64'(red),        64'd0);
        chk({tag, "_yellow"}, 64'(yellow),     64'd0);
        chk({tag, "_turn"},   64'(turn),       64'd0);
        chk({tag, "_count"},  64'(move_count), 64'd0);
        chk({tag, "_lpos"},   64'(last_pos),   64'd0);
        chk({tag, "_winner"}, 64'(winner),     64'd0);
        chk({tag, "_over"},   64'(game_over),  64'd0);
        chk({tag, "_draw"},   64'(draw),       64'd0);
        chk({tag, "_pulses"}, 64'({drop_ack, drop_rej, check_red, check_yellow}), 64'd0);
    endtask

    task automatic do_drop(input int col, input logic win);
        exp_t e;
        exp_t g;
        int   r;
        int   lat_cnt;
        bit   got;
        r = -1;
        if (col < COLS) begin
            for (int rr = ROWS - 1; rr >= 0; rr--) begin
                if (!(red_m[rr*COLS+col] | yellow_m[rr*COLS+col])) begin
                    r = rr;
                    break;
                end
            end
            e.lat = (r < 0) ? ROWS + 1 : ROWS - r + 1;
        end else begin
            e.lat = 1;
        end
        e.is_ack = (r >= 0);
        e.pos    = (r >= 0) ? 6'(r * COLS + col) : 6'd0;
        e.chk_r  = e.is_ack && !turn_m;
        e.chk_y  = e.is_ack && turn_m;
        sb_q.push_back(e);
        win_arm = win;
        @(negedge clk);
        col_sel = 3'(col);
        drop    = 1'b1;
        @(posedge clk);
        #1 drop = 1'b0;
        lat_cnt = 0;
        got     = 1'b0;
        while (!got && lat_cnt < 20) begin
            @(negedge clk);
            lat_cnt++;
            if (drop_ack || drop_rej) got = 1'b1;
        end
        g = sb_q.pop_front();
        if (!got) begin
            chk("resp_timeout", 64'd0, 64'd1);
            return;
        end
        chk("ack",     64'(drop_ack),     64'(g.is_ack));
        chk("rej",     64'(drop_rej),     64'(!g.is_ack));
        chk("latency", 64'(lat_cnt),      64'(g.lat));
        chk("chk_red", 64'(check_red),    64'(g.chk_r));
        chk("chk_yel", 64'(check_yellow), 64'(g.chk_y));
        if (g.is_ack) begin
            if (turn_m) yellow_m[g.pos] = 1'b1;
            else        red_m[g.pos]    = 1'b1;
            count_m++;
            chk("last_pos", 64'(last_pos), 64'(g.pos));
            chk("board_r",  64'(red),      64'(red_m));
            chk("board_y",  64'(yellow),   64'(yellow_m));
            @(negedge clk);
            @(negedge clk);
            if (win) begin
                winner_m = turn_m ? 2'b10 : 2'b01;
                over_m   = 1'b1;
            end else if (count_m == N) begin
                draw_m = 1'b1;
                over_m = 1'b1;
            end else begin
                turn_m = ~turn_m;
            end
            chk("count",  64'(move_count), 64'(count_m));
        end else begin
            chk("rej_board_r", 64'(red),    64'(red_m));
            chk("rej_board_y", 64'(yellow), 64'(yellow_m));
        end
        chk("turn",   64'(turn),      64'(turn_m));
        chk("winner", 64'(winner),    64'(winner_m));
        chk("over",   64'(game_over), 64'(over_m));
        chk("draw",   64'(draw),      64'(draw_m));
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        #1 chk("clr_n_low", 64'(clr_n), 64'd0);
        @(posedge clk);
        #1 new_game = 1'b0;
        model_reset();
        @(negedge clk);
        chk("clr_n_high", 64'(clr_n), 64'd1);
        check_reset("ng");
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (drop_ack || drop_rej || check_red || check_yellow) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        drop     = 1'b0;
        new_game = 1'b0;
        col_sel  = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_clr_n", 64'(clr_n), 64'd1);
        check_reset("rst");
        resetn = 1'b1;

        do_drop(3, 1'b0);
        do_drop(3, 1'b0);
        for (int i = 0; i < ROWS; i++) do_drop(0, 1'b0);
        do_drop(0, 1'b0);
        do_drop(7, 1'b0);

        do_new_game();
        do_drop(0, 1'b0); do_drop(0, 1'b0);
        do_drop(1, 1'b0); do_drop(1, 1'b0);
        do_drop(2, 1'b0); do_drop(2, 1'b0);
        do_drop(3, 1'b1);
        chk("win_winner", 64'(winner), 64'd1);
        @(negedge clk);
        col_sel = 3'd4;
        drop    = 1'b1;
        expect_quiet("over_quiet", 8);
        drop = 1'b0;
        chk("over_board_r", 64'(red),       64'(red_m));
        chk("over_board_y", 64'(yellow),    64'(yellow_m));
        chk("over_hold",    64'(game_over), 64'd1);
        chk("over_turn",    64'(turn),      64'd0);

        do_new_game();
        for (int c = 0; c < COLS; c++) begin
            for (int i = 0; i < ROWS; i++) do_drop(c, 1'b0);
        end
        chk("draw_flag",  64'(draw),       64'd1);
        chk("draw_count", 64'(move_count), 64'd42);

        do_new_game();
        @(negedge clk);
        col_sel = 3'd2;
        drop    = 1'b1;
        @(posedge clk);
        #1 drop = 1'b0;
        new_game = 1'b1;
        #1 chk("find_clr_n", 64'(clr_n), 64'd0);
        @(posedge clk);
        #1 new_game = 1'b0;
        expect_quiet("find_ng_quiet", 5);
        check_reset("find_ng");

        @(negedge clk);
        col_sel = 3'd5;
        drop    = 1'b1;
        @(posedge clk);
        #1 drop = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b0;
        #1 check_reset("chk_rst");
        @(negedge clk);
        resetn = 1'b1;
        expect_quiet("chk_rst_quiet", 5);
        check_reset("chk_rst_after");
        chk("chk_rst_clr_n", 64'(clr_n), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/connect4_turn_ctrl.md
Name: connect4_turn_ctrl

Overview:
Game sequencer for the Connect Four board. It accepts a column request from the current player and scans the column to find the lowest free cell. It then writes the chip into the red/yellow occupancy vectors and pulses the win checker's check enable for that colour. Finally it evaluates win/draw and alternates turns. It sits between the player input/debounce logic and the win-condition checker, and owns the board state that the checker and display consume.

Parameters:
ROWS, 6, board rows; row 0 = top, row ROWS-1 = bottom
COLS, 7, board columns; cell index = row*COLS + col
FIRST_PLAYER, 0, player to move after reset/new game (0 = red, 1 = yellow)

Ports:
clk  in  1  system clock, all state on posedge
resetn  in  1  asynchronous active-low reset
col_sel  in  3  requested column, 0..COLS-1
drop  in  1  move request, sampled only in IDLE
new_game  in  1  synchronous clear of board and game state
red_win_in  in  1  registered red-win flag from win checker
yellow_win_in  in  1  registered yellow-win flag from win checker
red  out  ROWS*COLS  red occupancy vector
yellow  out  ROWS*COLS  yellow occupancy vector
check_red  out  1  one-cycle check enable to win checker
check_yellow  out  1  one-cycle check enable to win checker
clr_n  out  1  active-low checker clear; low for the cycle new_game is sampled
turn  out  1  player to move (0 red, 1 yellow)
drop_ack  out  1  one-cycle pulse: chip placed
drop_rej  out  1  one-cycle pulse: illegal move (bad column or full column)
last_pos  out  6  index of last placed chip
move_count  out  6  chips on board, 0..42
game_over  out  1  high in OVER state
winner  out  2  01 red, 10 yellow, 00 none/draw
draw  out  1  high in OVER when board full with no winner

Behaviour:
- Reset (async, resetn low): red=0, yellow=0, turn=FIRST_PLAYER, state=IDLE, move_count=0, last_pos=0, winner=00. All pulses, game_over, draw = 0. clr_n=1.
- States: IDLE, FIND, CHECK, EVAL, OVER.
- IDLE:
  - drop=1 and col_sel<COLS: latch col, scan_row<=ROWS-1, go FIND.
  - drop=1 and col_sel>=COLS: drop_rej pulses next cycle, stay IDLE.
- FIND: one row per cycle, index = scan_row*COLS+col.
  - Cell empty (red|yellow bit = 0): set the bit in the current player's vector, last_pos<=index, move_count+1, go CHECK.
  - Cell occupied and scan_row>0: scan_row-1.
  - Cell occupied and scan_row==0: column full; drop_rej pulse, go IDLE. No board change, turn unchanged.
- CHECK (1 cycle): assert check_red if turn=0, else check_yellow; drop_ack=1.
- EVAL (1 cycle): sample the win flag for the current player; the checker registers it at the CHECK edge.
  - Flag set: winner<=01 (red) or 10 (yellow), go OVER.
  - Else if move_count==ROWS*COLS: draw<=1, go OVER.
  - Else: toggle turn, go IDLE.
- OVER: game_over=1; drop ignored; board, winner and turn frozen.
- Latency: an empty bottom cell is accepted in IDLE at cycle 0. FIND is cycle 1 (bit written at its end), CHECK/drop_ack is cycle 2, EVAL is cycle 3, and IDLE resumes at cycle 4 with turn toggled. Each occupied cell below adds one FIND cycle; worst case is ROWS FIND cycles.
- drop outside IDLE is ignored, not queued. Requesters hold or re-issue it.
- new_game=1 in any state: synchronous clear to reset values, clr_n=0 that cycle, state IDLE. It has priority over drop and over any in-flight move.
- Reset mid-move: board and state clear immediately; no check pulse follows.
- check_red and check_yellow are never high together, and never high outside CHECK.

Test Plan:
- Reset, drop col 3 (red) -> red bit 38 set after FIND, drop_ack in cycle 2, check_red 1 cycle, turn=1 at cycle 4, move_count=1.
- Yellow drops col 3 on top of red -> yellow bit 31 set, 2 FIND cycles, last_pos=31, check_yellow pulses.
- Fill col 0 (6 alternating drops), then drop col 0 -> drop_rej after 6 FIND cycles, board unchanged, turn unchanged, no check pulse; col_sel=7 -> drop_rej with no FIND.
- Red plays cols 0,1,2,3 on the bottom row with yellow on row 4; model the checker raising red_win_in after the 4th CHECK -> winner=01, game_over=1, further drops ignored.
- Fill all 42 cells with no win flag -> after the 42nd EVAL draw=1, winner=00, move_count=42.
- Assert new_game during FIND and resetn during CHECK -> all outputs return to reset values, clr_n low one cycle for new_game, no stray check/ack pulse.
